// File: rtl/playcity_pkg.sv
// Shared types and constants for the PlayCity dual-YM2149 write sequencer.
package playcity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_OP,
        ST_RS_ADDR,
        ST_RS_DATA,
        ST_RS_RESTORE
    } state_t;

    typedef struct packed {
        logic [1:0] chip;
        logic       is_addr;
        logic [7:0] data;
    } fifo_entry_t;

    localparam logic BC_ADDR   = 1'b1;
    localparam logic BC_DATA   = 1'b0;
    localparam int   PSG_NREGS = 16;
    localparam int   REG_W     = $clog2(PSG_NREGS);

    function automatic logic [7:0] reg_byte(input logic [REG_W-1:0] r);
        return {{(8-REG_W){1'b0}}, r};
    endfunction

endpackage

// File: rtl/playcity_ay_sequencer_if.sv
// Request/response bundle between a host (CPU decode + savestate) and the
// PlayCity PSG sequencer.
interface playcity_ay_sequencer_if;
    import playcity_pkg::*;

    logic             soft_reset;
    logic             ay_ce;
    logic             cpu_we;
    logic [1:0]       cpu_chip;
    logic             cpu_is_addr;
    logic [7:0]       cpu_data;
    logic             fifo_full;
    logic             overflow;
    logic             rs_req;
    logic             rs_chip;
    logic [REG_W-1:0] rs_reg;
    logic [7:0]       rs_data;
    logic             rs_ack;
    logic             psg_bdir_l;
    logic             psg_bdir_r;
    logic             psg_bc;
    logic [7:0]       psg_do;
    logic             busy;

    modport master (
        output soft_reset, ay_ce,
        output cpu_we, cpu_chip, cpu_is_addr, cpu_data,
        output rs_req, rs_chip, rs_reg, rs_data,
        input  fifo_full, overflow, rs_ack,
        input  psg_bdir_l, psg_bdir_r, psg_bc, psg_do, busy
    );

    modport slave (
        input  soft_reset, ay_ce,
        input  cpu_we, cpu_chip, cpu_is_addr, cpu_data,
        input  rs_req, rs_chip, rs_reg, rs_data,
        output fifo_full, overflow, rs_ack,
        output psg_bdir_l, psg_bdir_r, psg_bc, psg_do, busy
    );

endinterface

// File: rtl/playcity_op_fifo.sv
// Synchronous FIFO of queued CPU PSG operations; a pop frees room for a
// push in the same cycle.
module playcity_op_fifo
    import playcity_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  fifo_entry_t din_i,
    input  logic        pop_i,
    output fifo_entry_t dout_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fifo_entry_t   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FIFO_DEPTH[AW:0]);
    assign dout_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: the count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/playcity_ay_sequencer.sv
// PlayCity PSG bus sequencer: arbitrates queued CPU ops against atomic
// savestate register loads and re-latches each chip's address afterwards.
module playcity_ay_sequencer
    import playcity_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    playcity_ay_sequencer_if.slave  bus
);

    state_t           state_q, state_d;
    fifo_entry_t      cur_q, cur_d;
    logic             rs_chip_q, rs_chip_d;
    logic [REG_W-1:0] rs_reg_q, rs_reg_d;
    logic [7:0]       rs_data_q, rs_data_d;
    logic [7:0]       shad_l_q, shad_l_d;
    logic [7:0]       shad_r_q, shad_r_d;
    logic             last_rs_q, last_rs_d;
    logic             overflow_q, overflow_d;

    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             ack;
    logic             bdir_l;
    logic             bdir_r;
    logic             bc;
    logic [7:0]       dout;

    // A write decoded with neither chip selected reaches no PSG.
    assign push       = bus.cpu_we && (bus.cpu_chip != 2'b00);
    assign push_entry = '{chip: bus.cpu_chip,
                          is_addr: bus.cpu_is_addr,
                          data: bus.cpu_data};

    playcity_op_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (bus.soft_reset),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign overflow_d = overflow_q || (push && full && !pop);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rs_chip_d = rs_chip_q;
        rs_reg_d  = rs_reg_q;
        rs_data_d = rs_data_q;
        shad_l_d  = shad_l_q;
        shad_r_d  = shad_r_q;
        last_rs_d = last_rs_q;
        pop       = 1'b0;
        ack       = 1'b0;
        bdir_l    = 1'b0;
        bdir_r    = 1'b0;
        bc        = BC_DATA;
        dout      = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                // On contention the side not served last time wins.
                if (!empty && (!bus.rs_req || last_rs_q)) begin
                    state_d   = ST_CPU_OP;
                    cur_d     = head;
                    last_rs_d = 1'b0;
                end else if (bus.rs_req) begin
                    state_d   = ST_RS_ADDR;
                    rs_chip_d = bus.rs_chip;
                    rs_reg_d  = bus.rs_reg;
                    rs_data_d = bus.rs_data;
                    last_rs_d = 1'b1;
                end
            end
            ST_CPU_OP: begin
                bdir_l = cur_q.chip[0];
                bdir_r = cur_q.chip[1];
                bc     = cur_q.is_addr;
                dout   = cur_q.data;
                if (bus.ay_ce) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                    if (cur_q.is_addr && cur_q.chip[0]) begin
                        shad_l_d = cur_q.data;
                    end
                    if (cur_q.is_addr && cur_q.chip[1]) begin
                        shad_r_d = cur_q.data;
                    end
                end
            end
            ST_RS_ADDR: begin
                bdir_l = !rs_chip_q;
                bdir_r = rs_chip_q;
                bc     = BC_ADDR;
                dout   = reg_byte(rs_reg_q);
                if (bus.ay_ce) begin
                    state_d = ST_RS_DATA;
                end
            end
            ST_RS_DATA: begin
                bdir_l = !rs_chip_q;
                bdir_r = rs_chip_q;
                bc     = BC_DATA;
                dout   = rs_data_q;
                if (bus.ay_ce) begin
                    state_d = ST_RS_RESTORE;
                end
            end
            ST_RS_RESTORE: begin
                bdir_l = !rs_chip_q;
                bdir_r = rs_chip_q;
                bc     = BC_ADDR;
                dout   = rs_chip_q ? shad_r_q : shad_l_q;
                if (bus.ay_ce) begin
                    ack     = !bus.soft_reset;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            rs_chip_q  <= 1'b0;
            rs_reg_q   <= '0;
            rs_data_q  <= 8'h00;
            shad_l_q   <= 8'h00;
            shad_r_q   <= 8'h00;
            last_rs_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.soft_reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            rs_chip_q  <= 1'b0;
            rs_reg_q   <= '0;
            rs_data_q  <= 8'h00;
            shad_l_q   <= 8'h00;
            shad_r_q   <= 8'h00;
            last_rs_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rs_chip_q  <= rs_chip_d;
            rs_reg_q   <= rs_reg_d;
            rs_data_q  <= rs_data_d;
            shad_l_q   <= shad_l_d;
            shad_r_q   <= shad_r_d;
            last_rs_q  <= last_rs_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.psg_bdir_l = bdir_l;
    assign bus.psg_bdir_r = bdir_r;
    assign bus.psg_bc     = bc;
    assign bus.psg_do     = dout;
    assign bus.rs_ack     = ack;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.fifo_full  = full;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_playcity_ay_sequencer.sv
// Directed scoreboard bench for playcity_ay_sequencer: expected PSG bus ops
// are queued with the stimulus and checked as each op completes.
module tb_playcity_ay_sequencer;
    import playcity_pkg::*;

    typedef struct packed {
        logic       l;
        logic       r;
        logic       bc;
        logic [7:0] d;
    } op_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ce    = 1'b0;
    int   ncmp    = 0;
    int   nerr    = 0;
    int   ack_cnt = 0;
    int   ce_mode = 0;
    int   cyc     = 0;
    int   base    = 0;
    op_t  exp_q[$];
    op_t  mon_o;
    op_t  mon_e;

    playcity_ay_sequencer_if bus();

    assign bus.ay_ce = ce;

    playcity_ay_sequencer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ay_ce: 0 = held low, 1 = every 4th clock, 2 = held high
    always @(posedge clock) begin
        #2;
        cyc++;
        ce = (ce_mode == 2) || (ce_mode == 1 && (cyc % 4) == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && !bus.soft_reset) begin
            if (bus.rs_ack) ack_cnt++;
            if (bus.ay_ce && (bus.psg_bdir_l || bus.psg_bdir_r)) begin
                mon_o = '{l: bus.psg_bdir_l, r: bus.psg_bdir_r,
                          bc: bus.psg_bc, d: bus.psg_do};
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $error("FAIL unexpected_op observed=%0h expected=none",
                           mon_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bus_op", 32'(mon_o), 32'(mon_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic a,
                        input logic [7:0] d);
        bus.cpu_we      = 1'b1;
        bus.cpu_chip    = c;
        bus.cpu_is_addr = a;
        bus.cpu_data    = d;
        tick();
        bus.cpu_we      = 1'b0;
    endtask

    task automatic expect_op(input logic l, input logic r, input logic b,
                             input logic [7:0] d);
        exp_q.push_back('{l: l, r: r, bc: b, d: d});
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.busy) break;
        end
        chk(tag, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.rs_ack) break;
        end
        chk(tag, 32'(bus.rs_ack), 32'd1);
    endtask

    function automatic logic [14:0] all_out();
        return {bus.psg_bdir_l, bus.psg_bdir_r, bus.psg_bc, bus.psg_do,
                bus.busy, bus.fifo_full, bus.overflow, bus.rs_ack};
    endfunction

    function automatic logic [10:0] drv();
        return {bus.psg_bdir_l, bus.psg_bdir_r, bus.psg_bc, bus.psg_do};
    endfunction

    initial begin
        bus.soft_reset  = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_chip    = 2'b00;
        bus.cpu_is_addr = 1'b0;
        bus.cpu_data    = 8'h00;
        bus.rs_req      = 1'b0;
        bus.rs_chip     = 1'b0;
        bus.rs_reg      = 4'h0;
        bus.rs_data     = 8'h00;

        @(negedge clock);
        chk("reset_outputs", 32'(all_out()), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        ce_mode = 1;

        push(2'b00, 1'b0, 8'h99);
        repeat (3) tick();
        @(negedge clock);
        chk("null_chip", {30'd0, bus.busy, bus.overflow}, 32'd0);

        tick();
        expect_op(1'b1, 1'b0, 1'b1, 8'h07);
        push(2'b01, 1'b1, 8'h07);
        wait_busy("addr_grant");
        chk("addr_drive", 32'(drv()), 32'({1'b1, 1'b0, 1'b1, 8'h07}));
        wait_drain("addr_drain");
        @(negedge clock);
        chk("addr_idle", 32'(all_out()), 32'd0);

        tick();
        ce_mode = 2;
        expect_op(1'b1, 1'b1, 1'b0, 8'h55);
        push(2'b11, 1'b0, 8'h55);
        wait_busy("both_grant");
        chk("both_drive", 32'(drv()), 32'({1'b1, 1'b1, 1'b0, 8'h55}));
        wait_drain("both_drain");

        tick();
        ce_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) push(2'b01, 1'b0, 8'(i));
        @(negedge clock);
        chk("full_after4", {30'd0, bus.fifo_full, bus.overflow}, 32'd2);
        tick();
        push(2'b01, 1'b0, 8'h04);
        @(negedge clock);
        chk("ovf_set", {30'd0, bus.fifo_full, bus.overflow}, 32'd3);
        for (int i = 0; i < 4; i++) expect_op(1'b1, 1'b0, 1'b0, 8'(i));
        tick();
        ce_mode = 1;
        wait_drain("ovf_drain");
        @(negedge clock);
        chk("ovf_sticky", {30'd0, bus.fifo_full, bus.overflow}, 32'd1);
        tick();
        bus.soft_reset = 1'b1;
        tick();
        bus.soft_reset = 1'b0;
        @(negedge clock);
        chk("ovf_clear", 32'(all_out()), 32'd0);

        tick();
        expect_op(1'b1, 1'b0, 1'b1, 8'h07);
        push(2'b01, 1'b1, 8'h07);
        wait_drain("rs_latch");
        tick();
        base = ack_cnt;
        bus.rs_req  = 1'b1;
        bus.rs_chip = 1'b0;
        bus.rs_reg  = 4'hA;
        bus.rs_data = 8'h3F;
        expect_op(1'b1, 1'b0, 1'b1, 8'h0A);
        expect_op(1'b1, 1'b0, 1'b0, 8'h3F);
        expect_op(1'b1, 1'b0, 1'b1, 8'h07);
        wait_busy("rs_grant");
        tick();
        bus.rs_chip = 1'b1;
        bus.rs_reg  = 4'hF;
        bus.rs_data = 8'hEE;
        wait_ack("rs_ack_seen");
        tick();
        bus.rs_req = 1'b0;
        @(negedge clock);
        chk("rs_ack_pulse", {30'd0, bus.rs_ack, bus.busy}, 32'd0);
        chk("rs_ack_count", ack_cnt - base, 1);
        chk("rs_ops_done", exp_q.size(), 0);

        tick();
        bus.soft_reset = 1'b1;
        tick();
        bus.soft_reset = 1'b0;
        ce_mode = 0;
        tick();
        base = ack_cnt;
        expect_op(1'b0, 1'b1, 1'b1, 8'h05);
        push(2'b10, 1'b1, 8'h05);
        push(2'b10, 1'b0, 8'h11);
        push(2'b10, 1'b0, 8'h22);
        bus.rs_req  = 1'b1;
        bus.rs_chip = 1'b0;
        bus.rs_reg  = 4'hB;
        bus.rs_data = 8'h99;
        expect_op(1'b1, 1'b0, 1'b1, 8'h0B);
        expect_op(1'b1, 1'b0, 1'b0, 8'h99);
        expect_op(1'b1, 1'b0, 1'b1, 8'h00);
        expect_op(1'b0, 1'b1, 1'b0, 8'h11);
        expect_op(1'b0, 1'b1, 1'b1, 8'h03);
        expect_op(1'b0, 1'b1, 1'b0, 8'h44);
        expect_op(1'b0, 1'b1, 1'b1, 8'h05);
        expect_op(1'b0, 1'b1, 1'b0, 8'h22);
        tick();
        ce_mode = 1;
        wait_ack("ct_ack1");
        tick();
        bus.rs_chip = 1'b1;
        bus.rs_reg  = 4'h3;
        bus.rs_data = 8'h44;
        wait_ack("ct_ack2");
        tick();
        bus.rs_req = 1'b0;
        wait_drain("ct_drain");
        chk("ct_acks", ack_cnt - base, 2);

        tick();
        ce_mode = 0;
        base = ack_cnt;
        tick();
        bus.rs_req  = 1'b1;
        bus.rs_chip = 1'b0;
        bus.rs_reg  = 4'h1;
        bus.rs_data = 8'h02;
        expect_op(1'b1, 1'b0, 1'b1, 8'h01);
        wait_busy("ab_grant");
        tick();
        push(2'b01, 1'b0, 8'hAA);
        ce_mode = 2;
        tick();
        ce_mode = 0;
        @(negedge clock);
        chk("ab_rs_data", {bus.psg_bdir_l, bus.psg_bdir_r, bus.psg_bc,
                           bus.psg_do, bus.busy},
            32'({1'b1, 1'b0, 1'b0, 8'h02, 1'b1}));
        tick();
        bus.soft_reset = 1'b1;
        bus.rs_req     = 1'b0;
        tick();
        bus.soft_reset = 1'b0;
        @(negedge clock);
        chk("ab_soft_out", 32'(all_out()), 32'd0);
        tick();
        ce_mode = 1;
        repeat (12) tick();
        @(negedge clock);
        chk("ab_idle", 32'(bus.busy), 32'd0);
        chk("ab_no_ack", ack_cnt - base, 0);
        chk("ab_queue", exp_q.size(), 0);

        tick();
        ce_mode = 0;
        tick();
        push(2'b01, 1'b0, 8'h66);
        wait_busy("ar_grant");
        chk("ar_drive", 32'(drv()), 32'({1'b1, 1'b0, 1'b0, 8'h66}));
        #1;
        reset = 1'b1;
        #1;
        chk("ar_out", 32'(all_out()), 32'd0);
        tick();
        reset = 1'b0;
        ce_mode = 1;
        repeat (12) tick();
        @(negedge clock);
        chk("ar_idle", 32'(bus.busy), 32'd0);
        chk("ar_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
